// File: rtl/shift_sequencer.sv
// shift_sequencer
//   Turns a single ALU shift request into an N-cycle job for a 1-bit-per-cycle
//   logical shifter. It issues LOAD (11) once, then one step command per bit
//   (01 = right, 10 = left), and holds (00) otherwise. A 1-cycle done pulse
//   marks the cycle in which the shifter output is the final result.
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   asynchronous, active-low reset
//   start    in   request strobe, sampled only in IDLE
//   dir      in   0 = right, 1 = left (captured with start)
//   amount   in   number of 1-bit steps (captured with start, saturates at WIDTH)
//   operand  in   value to shift (captured with start)
//   abort    in   cancels a job in LOAD or SHIFT, no done pulse
//   sh_dout  in   shifter output register (feedback)
//   sh_sel   out  registered shifter command
//   sh_din   out  shifter data input: captured operand in LOAD, feedback otherwise
//   busy     out  high while in LOAD and SHIFT
//   done     out  1-cycle completion pulse
//   result   out  shifter output, final when done = 1
module shift_sequencer #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AMT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dir,
  input  logic [AMT_W-1:0] amount,
  input  logic [WIDTH-1:0] operand,
  input  logic             abort,
  input  logic [WIDTH-1:0] sh_dout,
  output logic [1:0]       sh_sel,
  output logic [WIDTH-1:0] sh_din,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  // Counter is wide enough for both the raw amount (plus one bit) and WIDTH,
  // so the saturation compare and the count itself can never wrap.
  localparam int unsigned CNT_W = ($clog2(WIDTH + 1) > AMT_W + 1) ?
                                  $clog2(WIDTH + 1) : AMT_W + 1;

  localparam logic [1:0] SEL_HOLD  = 2'b00;
  localparam logic [1:0] SEL_RIGHT = 2'b01;
  localparam logic [1:0] SEL_LEFT  = 2'b10;
  localparam logic [1:0] SEL_LOAD  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_sel,   w_sel_nxt;
  logic             r_busy,  w_busy_nxt;
  logic             r_done,  w_done_nxt;
  logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
  logic [WIDTH-1:0] r_op,    w_op_nxt;
  logic             r_dir,   w_dir_nxt;
  logic [CNT_W-1:0] w_amt_ext;
  logic [CNT_W-1:0] w_amt_sat;

  assign w_amt_ext = CNT_W'(amount);
  assign w_amt_sat = (w_amt_ext > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : w_amt_ext;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_sel   <= SEL_HOLD;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
      r_op    <= '0;
      r_dir   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_cnt   <= w_cnt_nxt;
      r_op    <= w_op_nxt;
      r_dir   <= w_dir_nxt;
    end
  end

  // Next-state logic. sh_sel, busy and done are registered, so their next
  // values are decided here together with the transition that implies them.
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_cnt_nxt   = r_cnt;
    w_op_nxt    = r_op;
    w_dir_nxt   = r_dir;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_LOAD;
          w_op_nxt    = operand;
          w_dir_nxt   = dir;
          w_cnt_nxt   = w_amt_sat;
          w_sel_nxt   = SEL_LOAD;
          w_busy_nxt  = 1'b1;
        end
      end
      S_LOAD: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
          w_sel_nxt   = SEL_HOLD;
          w_busy_nxt  = 1'b0;
        end else if (r_cnt != '0) begin
          w_state_nxt = S_SHIFT;
          w_sel_nxt   = r_dir ? SEL_LEFT : SEL_RIGHT;
        end else begin
          w_state_nxt = S_DONE;
          w_sel_nxt   = SEL_HOLD;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end
      end
      S_SHIFT: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
          w_sel_nxt   = SEL_HOLD;
          w_busy_nxt  = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
          // The step command issued on this edge is the last one.
          if (r_cnt == CNT_W'(1)) begin
            w_state_nxt = S_DONE;
            w_sel_nxt   = SEL_HOLD;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_sel_nxt   = SEL_HOLD;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // Output logic
  always_comb begin
    sh_din = (r_state == S_LOAD) ? r_op : sh_dout;
  end

  assign sh_sel = r_sel;
  assign busy   = r_busy;
  assign done   = r_done;
  assign result = sh_dout;

endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer
//   Self-checking bench for shift_sequencer. A behavioural 1-bit shifter closes
//   the loop on sh_sel/sh_din/sh_dout. Table vectors push their expected result
//   onto a scoreboard queue at start and pop it when done is observed; hand
//   sequences cover start-while-busy, abort and reset mid-job.
module tb_shift_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        dir;
  logic [4:0]  amount;
  logic [15:0] operand;
  logic        abort;
  logic [15:0] sh_dout;
  logic [1:0]  sh_sel;
  logic [15:0] sh_din;
  logic        busy;
  logic        done;
  logic [15:0] result;

  shift_sequencer #(.WIDTH(16), .AMT_W(5)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .dir     (dir),
    .amount  (amount),
    .operand (operand),
    .abort   (abort),
    .sh_dout (sh_dout),
    .sh_sel  (sh_sel),
    .sh_din  (sh_din),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-step shifter, reset by the same rst.
  always @(posedge clk or negedge rst) begin
    if (!rst) sh_dout <= '0;
    else begin
      case (sh_sel)
        2'b11:   sh_dout <= sh_din;
        2'b01:   sh_dout <= sh_dout >> 1;
        2'b10:   sh_dout <= sh_dout << 1;
        default: sh_dout <= sh_dout;
      endcase
    end
  end

  int unsigned done_cnt = 0;
  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

  typedef struct {
    logic [15:0] op;
    logic        d;
    logic [4:0]  amt;
    logic [15:0] exp;
    int unsigned n;
  } vec_t;

  typedef struct {
    logic [15:0] res;
    int unsigned n;
  } exp_t;

  exp_t        sb[$];
  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic wait_done();
    int unsigned cyc;
    cyc = 0;
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    chk("done_seen", {31'd0, done}, 32'd1);
  endtask

  task automatic pop_result(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      chk({name, "_sb_nonempty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk(name, {16'd0, result}, {16'd0, e.res});
    end
  endtask

  task automatic run_vec(input vec_t v);
    int unsigned cyc, loads, steps, wrong, busyc;
    logic [1:0]  step_code;
    exp_t        e;
    step_code = v.d ? 2'b10 : 2'b01;
    @(negedge clk);
    start = 1'b1; operand = v.op; dir = v.d; amount = v.amt;
    sb.push_back('{res: v.exp, n: v.n});
    @(negedge clk);
    start = 1'b0; operand = 16'hDEAD; dir = ~v.d; amount = 5'd9;
    chk("load_din", {16'd0, sh_din}, {16'd0, v.op});
    cyc = 1; loads = 0; steps = 0; wrong = 0; busyc = 0;
    while (!done && cyc < 60) begin
      if (sh_sel == 2'b11) loads++;
      else if (sh_sel == step_code) steps++;
      else if (sh_sel != 2'b00) wrong++;
      if (busy) busyc++;
      @(negedge clk);
      cyc++;
    end
    chk("done_seen", {31'd0, done}, 32'd1);
    if (sb.size() == 0) begin
      chk("sb_nonempty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("result", {16'd0, result}, {16'd0, e.res});
      chk("latency", cyc, e.n + 2);
      chk("steps", steps, e.n);
      chk("busy_cycles", busyc, e.n + 1);
    end
    chk("loads", loads, 32'd1);
    chk("wrong_dir", wrong, 32'd0);
    @(negedge clk);
    chk("done_width", {31'd0, done}, 32'd0);
    chk("idle_sel", {30'd0, sh_sel}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);
  endtask

  vec_t        tv[8];
  int unsigned base;

  initial begin
    tv[0] = '{16'h0001, 1'b1, 5'd4,  16'h0010, 4};
    tv[1] = '{16'h8000, 1'b0, 5'd15, 16'h0001, 15};
    tv[2] = '{16'h1234, 1'b0, 5'd0,  16'h1234, 0};
    tv[3] = '{16'hFFFF, 1'b1, 5'd20, 16'h0000, 16};
    tv[4] = '{16'hBEEF, 1'b0, 5'd16, 16'h0000, 16};
    tv[5] = '{16'hA5C3, 1'b1, 5'd7,  16'hE180, 7};
    tv[6] = '{16'h00F0, 1'b0, 5'd31, 16'h0000, 16};
    tv[7] = '{16'h8001, 1'b0, 5'd1,  16'h4000, 1};

    rst = 1'b0; start = 1'b0; dir = 1'b0; amount = '0; operand = '0; abort = 1'b0;
    @(negedge clk);
    chk("rst_sel",    {30'd0, sh_sel}, 32'd0);
    chk("rst_busy",   {31'd0, busy},   32'd0);
    chk("rst_done",   {31'd0, done},   32'd0);
    chk("rst_result", {16'd0, result}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(tv[i]);

    // Start while busy and while in DONE: both ignored, exactly one done pulse.
    base = done_cnt;
    @(negedge clk);
    start = 1'b1; operand = 16'h0001; dir = 1'b1; amount = 5'd3;
    sb.push_back('{res: 16'h0008, n: 3});
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; operand = 16'hAAAA; dir = 1'b0; amount = 5'd1;
    chk("busy_in_shift", {31'd0, busy}, 32'd1);
    @(negedge clk);
    start = 1'b0;
    wait_done();
    pop_result("busy_start_result");
    start = 1'b1; operand = 16'hAAAA;
    @(negedge clk);
    start = 1'b0;
    chk("done_start_sel",  {30'd0, sh_sel}, 32'd0);
    chk("done_start_busy", {31'd0, busy},   32'd0);
    @(negedge clk);
    chk("one_done_pulse", done_cnt - base, 32'd1);
    chk("result_intact",  {16'd0, result}, 32'h0008);

    // Abort at the third SHIFT cycle: partial shifter contents, no done.
    base = done_cnt;
    @(negedge clk);
    start = 1'b1; operand = 16'hFFFF; dir = 1'b0; amount = 5'd10;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    abort = 1'b1;
    chk("busy_before_abort", {31'd0, busy}, 32'd1);
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy",    {31'd0, busy},   32'd0);
    chk("abort_sel",     {30'd0, sh_sel}, 32'd0);
    chk("abort_done",    {31'd0, done},   32'd0);
    chk("abort_partial", {16'd0, result}, 32'h1FFF);
    repeat (15) @(negedge clk);
    chk("abort_no_done", done_cnt - base, 32'd0);

    // Abort while in LOAD.
    base = done_cnt;
    @(negedge clk);
    start = 1'b1; operand = 16'h0F0F; dir = 1'b1; amount = 5'd5;
    @(negedge clk);
    start = 1'b0; abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_load_busy", {31'd0, busy},   32'd0);
    chk("abort_load_sel",  {30'd0, sh_sel}, 32'd0);
    repeat (10) @(negedge clk);
    chk("abort_load_no_done", done_cnt - base, 32'd0);

    // Start and abort together in IDLE: start wins.
    @(negedge clk);
    start = 1'b1; abort = 1'b1; operand = 16'h0003; dir = 1'b1; amount = 5'd2;
    sb.push_back('{res: 16'h000C, n: 2});
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", {31'd0, busy},   32'd1);
    chk("start_abort_sel",  {30'd0, sh_sel}, 32'd3);
    wait_done();
    pop_result("start_abort_result");

    // Asynchronous reset mid-job.
    @(negedge clk);
    start = 1'b1; operand = 16'h00FF; dir = 1'b1; amount = 5'd12;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_sel",    {30'd0, sh_sel}, 32'd0);
    chk("midrst_busy",   {31'd0, busy},   32'd0);
    chk("midrst_done",   {31'd0, done},   32'd0);
    chk("midrst_result", {16'd0, result}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("postrst_busy", {31'd0, busy}, 32'd0);
    run_vec(tv[0]);

    chk("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

endmodule
